// File: rtl/ram_ring_addresser_pkg.sv
// Shared helpers for the ring-buffer address generator: pointer wrap
// function and count-width calculation.
package ram_addr_pkg;

    localparam int MAX_ADDR_W = 32;

    typedef logic [MAX_ADDR_W-1:0] addr_t;

    // Next address inside the window; LAST wraps back to FIRST.
    function automatic addr_t next_addr(input addr_t ptr, input addr_t first,
                                        input addr_t last, input logic down);
        if (ptr == last)
            return first;
        else if (down)
            return ptr - addr_t'(1);
        else
            return ptr + addr_t'(1);
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ram_ring_addresser_ptr.sv
// Single wrapping pointer over [FIRST..LAST]; moves one step when advance
// is high and returns to FIRST on reset or clr.
module ram_ptr
    import ram_addr_pkg::*;
#(
    parameter int               ADDR_W = 11,
    parameter logic [ADDR_W-1:0] FIRST = '0,
    parameter logic [ADDR_W-1:0] LAST  = '0,
    parameter bit               DOWN   = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] nxt;

    // Widen into the package function, then truncate back; the result always
    // lies inside the window so no significant bits are lost.
    assign nxt = ADDR_W'(next_addr(addr_t'(addr), addr_t'(FIRST), addr_t'(LAST), DOWN));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            addr <= FIRST;
        else if (clr)
            addr <= FIRST;
        else if (advance)
            addr <= nxt;
    end

endmodule

// File: rtl/ram_ring_addresser.sv
// Dual-pointer circular buffer address generator with fill count, full/empty
// decode and sticky overflow/underflow flags.
module ram_ring_addresser
    import ram_addr_pkg::*;
#(
    parameter  int ADDR_W    = 11,
    parameter  int DEPTH     = 2048,
    parameter  int BASE      = 0,
    parameter  int DOWN      = 1,
    parameter  int OVERWRITE = 1,
    localparam int CW        = count_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_ok,
    output logic              rd_ok,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty,
    output logic              wr_wrap,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W-1:0] FIRST   = ADDR_W'((DOWN != 0) ? BASE + DEPTH - 1 : BASE);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'((DOWN != 0) ? BASE : BASE + DEPTH - 1);
    localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
    localparam logic              OW      = (OVERWRITE != 0);

    if (DEPTH < 2 || longint'(BASE) + longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_bad_cfg
        $error("ram_ring_addresser: window does not fit the address space");
    end

    logic rd_adv;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // A same-cycle read frees a slot, so a write to a full buffer is still
    // accepted alongside an accepted read even without overwrite.
    assign rd_ok   = rd_en & ~empty & ~clr;
    assign wr_ok   = wr_en & ~clr & (~full | OW | rd_ok);
    assign wr_wrap = wr_ok & (wr_addr == LAST);

    // Overwriting a full buffer drops the oldest entry by pushing rd along.
    assign rd_adv = rd_ok | (wr_ok & full & ~rd_ok);

    ram_ptr #(.ADDR_W(ADDR_W), .FIRST(FIRST), .LAST(LAST), .DOWN(DOWN != 0)) u_wr_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .advance (wr_ok),
        .addr    (wr_addr)
    );

    ram_ptr #(.ADDR_W(ADDR_W), .FIRST(FIRST), .LAST(LAST), .DOWN(DOWN != 0)) u_rd_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .advance (rd_adv),
        .addr    (rd_addr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok && !rd_ok && !full)
                count <= count + 1'b1;
            else if (rd_ok && !wr_ok)
                count <= count - 1'b1;
            if (wr_en && full && !rd_ok)
                overflow <= 1'b1;
            if (rd_en && empty)
                underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ram_ring_addresser.sv
// Randomised bench for ram_ring_addresser: three configurations driven by the
// same stimulus and compared each cycle against an index/occupancy model.
module tb_ram_ring_addresser;

    logic clk = 1'b0;
    logic reset_n, clr, wr_en, rd_en;

    always #5 clk = ~clk;

    logic [3:0] wa0, ra0, c0, wa1, ra1, c1;
    logic [2:0] wa2, ra2, c2;
    logic wok0, rok0, f0, e0, ww0, ov0, un0;
    logic wok1, rok1, f1, e1, ww1, ov1, un1;
    logic wok2, rok2, f2, e2, ww2, ov2, un2;

    ram_ring_addresser #(.ADDR_W(4), .DEPTH(8), .BASE(4), .DOWN(1), .OVERWRITE(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .clr(clr), .wr_en(wr_en), .rd_en(rd_en),
        .wr_addr(wa0), .rd_addr(ra0), .wr_ok(wok0), .rd_ok(rok0), .count(c0),
        .full(f0), .empty(e0), .wr_wrap(ww0), .overflow(ov0), .underflow(un0));

    ram_ring_addresser #(.ADDR_W(4), .DEPTH(8), .BASE(4), .DOWN(1), .OVERWRITE(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .clr(clr), .wr_en(wr_en), .rd_en(rd_en),
        .wr_addr(wa1), .rd_addr(ra1), .wr_ok(wok1), .rd_ok(rok1), .count(c1),
        .full(f1), .empty(e1), .wr_wrap(ww1), .overflow(ov1), .underflow(un1));

    ram_ring_addresser #(.ADDR_W(3), .DEPTH(5), .BASE(0), .DOWN(0), .OVERWRITE(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .clr(clr), .wr_en(wr_en), .rd_en(rd_en),
        .wr_addr(wa2), .rd_addr(ra2), .wr_ok(wok2), .rd_ok(rok2), .count(c2),
        .full(f2), .empty(e2), .wr_wrap(ww2), .overflow(ov2), .underflow(un2));

    int obs_wa[3], obs_ra[3], obs_cnt[3], obs_wok[3], obs_rok[3];
    int obs_full[3], obs_empty[3], obs_wrap[3], obs_ovf[3], obs_unf[3];

    always_comb begin
        obs_wa    = '{int'(wa0), int'(wa1), int'(wa2)};
        obs_ra    = '{int'(ra0), int'(ra1), int'(ra2)};
        obs_cnt   = '{int'(c0), int'(c1), int'(c2)};
        obs_wok   = '{int'(wok0), int'(wok1), int'(wok2)};
        obs_rok   = '{int'(rok0), int'(rok1), int'(rok2)};
        obs_full  = '{int'(f0), int'(f1), int'(f2)};
        obs_empty = '{int'(e0), int'(e1), int'(e2)};
        obs_wrap  = '{int'(ww0), int'(ww1), int'(ww2)};
        obs_ovf   = '{int'(ov0), int'(ov1), int'(ov2)};
        obs_unf   = '{int'(un0), int'(un1), int'(un2)};
    end

    // Model: the window is a sequence of DEPTH slots; pointers are slot
    // indices and occupancy is a plain integer.
    int m_depth[3] = '{8, 8, 5};
    int m_first[3] = '{11, 11, 0};
    int m_down[3]  = '{1, 1, 0};
    int m_ow[3]    = '{1, 0, 1};
    int wi[3], ri[3], cnt[3], ovf[3], unf[3];

    int nChecks = 0;
    int nFails  = 0;

    function automatic int addrOf(int k, int idx);
        return (m_down[k] != 0) ? m_first[k] - idx : m_first[k] + idx;
    endfunction

    function automatic int expRd(int k);
        return (rd_en && !clr && cnt[k] > 0) ? 1 : 0;
    endfunction

    function automatic int expWr(int k);
        return (wr_en && !clr && (cnt[k] < m_depth[k] || m_ow[k] != 0 || expRd(k) != 0)) ? 1 : 0;
    endfunction

    task automatic checkOutput(input string tag, input int obs, input int exp);
        nChecks++;
        if (obs != exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 3; k++) begin
            wi[k] = 0; ri[k] = 0; cnt[k] = 0; ovf[k] = 0; unf[k] = 0;
        end
    endtask

    task automatic checkAll();
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("d%0d wr_addr", k), obs_wa[k], addrOf(k, wi[k]));
            checkOutput($sformatf("d%0d rd_addr", k), obs_ra[k], addrOf(k, ri[k]));
            checkOutput($sformatf("d%0d count", k), obs_cnt[k], cnt[k]);
            checkOutput($sformatf("d%0d full", k), obs_full[k], (cnt[k] == m_depth[k]) ? 1 : 0);
            checkOutput($sformatf("d%0d empty", k), obs_empty[k], (cnt[k] == 0) ? 1 : 0);
            checkOutput($sformatf("d%0d overflow", k), obs_ovf[k], ovf[k]);
            checkOutput($sformatf("d%0d underflow", k), obs_unf[k], unf[k]);
            checkOutput($sformatf("d%0d wr_ok", k), obs_wok[k], expWr(k));
            checkOutput($sformatf("d%0d rd_ok", k), obs_rok[k], expRd(k));
            checkOutput($sformatf("d%0d wr_wrap", k), obs_wrap[k],
                        (expWr(k) != 0 && wi[k] == m_depth[k] - 1) ? 1 : 0);
        end
    endtask

    task automatic modelStep();
        int eW, eR, d;
        for (int k = 0; k < 3; k++) begin
            eW = expWr(k);
            eR = expRd(k);
            d  = m_depth[k];
            if (clr) begin
                wi[k] = 0; ri[k] = 0; cnt[k] = 0; ovf[k] = 0; unf[k] = 0;
            end else begin
                if (wr_en && cnt[k] == d && eR == 0) ovf[k] = 1;
                if (rd_en && cnt[k] == 0) unf[k] = 1;
                if (eW != 0) wi[k] = (wi[k] + 1) % d;
                if (eR != 0) ri[k] = (ri[k] + 1) % d;
                if (eW != 0 && eR == 0) begin
                    if (cnt[k] < d) cnt[k]++;
                    else ri[k] = (ri[k] + 1) % d;
                end else if (eR != 0 && eW == 0) begin
                    cnt[k]--;
                end
            end
        end
    endtask

    // One clock cycle: drive after the falling edge, check, advance the model
    // at the rising edge, then return the inputs to idle.
    task automatic applyStimulus(input logic w, input logic r, input logic c);
        @(negedge clk);
        wr_en = w; rd_en = r; clr = c;
        #1;
        checkAll();
        modelStep();
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checkOutput("reset wr_addr", int'(wa0), 11);
        checkOutput("reset rd_addr", int'(ra0), 11);
        checkOutput("reset empty", int'(e0), 1);
        checkAll();

        $display("[TB] filling buffer");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("fill wr_addr", int'(wa0), 11);
        checkOutput("fill count", int'(c0), 8);
        checkOutput("fill full", int'(f0), 1);

        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("nooverwrite wr_addr", int'(wa1), 11);
        checkOutput("nooverwrite overflow", int'(ov1), 1);
        checkOutput("overwrite rd_addr", int'(ra0), 10);
        checkOutput("overwrite count", int'(c0), 8);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("full wr+rd wr_addr", int'(wa1), 10);
        checkOutput("full wr+rd rd_addr", int'(ra1), 10);
        checkOutput("full wr+rd count", int'(c1), 8);

        $display("[TB] draining buffer");
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("empty read underflow", int'(un0), 1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("empty wr+rd count", int'(c0), 1);

        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("clr wr_addr", int'(wa2), 0);
        checkOutput("clr count", int'(c2), 0);
        checkOutput("clr underflow", int'(un0), 0);

        $display("[TB] random phase");
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                @(negedge clk);
                #2 reset_n = 1'b0;
                #1 modelReset();
                checkAll();
                @(negedge clk);
                reset_n = 1'b1;
            end
            applyStimulus($urandom_range(0, 99) < ((i % 200) < 100 ? 70 : 35),
                          $urandom_range(0, 99) < ((i % 200) < 100 ? 35 : 70),
                          $urandom_range(0, 99) < 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/ram_ring_addresser.md
Name: ram_ring_addresser

Overview:
Parametrised dual-pointer address generator for a circular sample buffer held in single-port or dual-port RAM. It tracks a write pointer and a read pointer over a configurable window [BASE, BASE+DEPTH-1], counting up or down. It reports fill level, full and empty, and sticky overflow/underflow. It sits between the sample capture logic (write side) and the readout/transfer logic (read side), and supersedes the single write-only down-counter.

Parameters:
ADDR_W, 11, RAM address width
DEPTH, 2048, number of buffer locations; elaboration error unless 2 <= DEPTH and BASE+DEPTH <= 2**ADDR_W
BASE, 0, lowest address of the window
DOWN, 1, 1 = pointers count down from BASE+DEPTH-1 to BASE; 0 = count up from BASE to BASE+DEPTH-1
OVERWRITE, 1, 1 = a write when full is accepted and drops the oldest entry; 0 = a write when full is rejected

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous, active-low reset
clr  input  1  synchronous clear to the reset state
wr_en  input  1  write request this cycle
rd_en  input  1  read request this cycle
wr_addr  output  ADDR_W  address of the current write
rd_addr  output  ADDR_W  address of the oldest unread entry
wr_ok  output  1  write request accepted this cycle (combinational)
rd_ok  output  1  read request accepted this cycle (combinational)
count  output  $clog2(DEPTH+1)  number of stored entries
full  output  1  count == DEPTH
empty  output  1  count == 0
wr_wrap  output  1  accepted write at LAST address this cycle (combinational)
overflow  output  1  sticky: a write hit a full buffer
underflow  output  1  sticky: a read was rejected because the buffer was empty

Behaviour:
- Reset is reset_n, asynchronous, active-low. Clock is clk, rising edge.
- FIRST and LAST addresses:
  - DOWN=1: FIRST = BASE+DEPTH-1, LAST = BASE.
  - DOWN=0: FIRST = BASE, LAST = BASE+DEPTH-1.
- Pointer advance: ptr <= (ptr == LAST) ? FIRST : ptr -/+ 1. Use ADDR_W-bit arithmetic only. Pointers never leave the window.
- Reset state and clr state are identical:
  - wr_addr = rd_addr = FIRST
  - count = 0, empty = 1, full = 0
  - overflow = 0, underflow = 0
- clr has priority over wr_en and rd_en. wr_ok and rd_ok are 0 while clr is high.
- wr_addr and rd_addr are register outputs. Data is written or read at the presented address in the same cycle the request is accepted; the pointer moves on the next edge.
- Read acceptance: rd_ok = rd_en & !empty.
  - When empty, rd_en is rejected and underflow is set. This holds even if wr_en is accepted in the same cycle; the new entry is not readable until the next cycle.
- Write acceptance:
  - wr_ok = wr_en & (!full | OVERWRITE | rd_ok).
- Per-cycle outcome table:
  - Write only, not full: wr pointer advances, count+1.
  - Read only: rd pointer advances, count-1.
  - Write and read both accepted: both pointers advance, count unchanged, no flag change.
  - Full, write, no read, OVERWRITE=1: write accepted; wr and rd pointers both advance; count stays DEPTH; overflow set.
  - Full, write, no read, OVERWRITE=0: write rejected; no pointer change; overflow set.
- full and empty are decoded from the count register, not from pointer equality.
- Sticky flags clear only on reset or clr.
- wr_wrap = wr_ok & (wr_addr == LAST).

Decomposition:
- Package ram_addr_pkg:
  - function next_addr(ptr, first, last, down)
  - localparam helper for the count width
- Sub-module ram_ptr:
  - single wrapping pointer with advance and clr inputs
  - instantiated twice (wr, rd)
- Top level holds the count, acceptance logic and flags.

Test Plan:
All cases use ADDR_W=4, DEPTH=8, BASE=4, DOWN=1 (FIRST=11, LAST=4) unless stated.
- Reset -> wr_addr=11, rd_addr=11, count=0, empty=1, full=0, overflow=0, underflow=0.
- 8 consecutive writes -> write addresses 11,10,...,4; wr_wrap high on the 8th write; after it wr_addr=11, count=8, full=1.
- OVERWRITE=0, full, 9th write -> wr_ok=0, wr_addr=11, count=8, overflow=1. Then wr_en+rd_en together -> both accepted, wr_addr=10, rd_addr=10, count=8.
- OVERWRITE=1, full, 9th write -> wr_ok=1 at addr 11, then rd_addr=10, count=8, overflow=1.
- Empty, rd_en only -> rd_ok=0, underflow=1, rd_addr=11. Then wr_en+rd_en while empty -> write accepted, read rejected, count=1, rd_addr=11.
- DOWN=0, BASE=0, DEPTH=5, ADDR_W=3; 6 writes -> addresses 0,1,2,3,4,0. Then clr asserted together with wr_en -> wr_addr=0, count=0, flags cleared, write ignored. Then reset_n asserted mid-burst -> immediate return to the reset state.
